// File: rtl/controle_porta_pkg.sv
// controle_porta_pkg: shared state encoding and default door timings.
// Contents: estado_t (FECHADA/ABRINDO/ABERTA/FECHANDO), default phase lengths,
//           duracao_fase() which maps a phase to its length in cycles.
package controle_porta_pkg;

   typedef enum logic [1:0] {
      FECHADA  = 2'd0,
      ABRINDO  = 2'd1,
      ABERTA   = 2'd2,
      FECHANDO = 2'd3
   } estado_t;

   localparam int T_ABRE_DEF     = 4;
   localparam int T_ESPERA_DEF   = 8;
   localparam int T_FECHA_DEF    = 4;
   localparam int N_DEF          = 4;
   localparam int MAX_REABRE_DEF = 3;

   // Length of a timed phase in cycles; FECHADA is untimed and returns 1 so
   // that the derived limit (length-1) is a harmless 0.
   function automatic int duracao_fase(estado_t e, int t_abre, int t_espera, int t_fecha);
      case (e)
         ABRINDO:  return t_abre;
         ABERTA:   return t_espera;
         FECHANDO: return t_fecha;
         default:  return 1;
      endcase
   endfunction

endpackage

// File: rtl/controle_porta_temporizador.sv
// temporizador_porta: N-bit phase timer shared by all door phases.
// Ports: clock/zera_as (async active-high reset), zera (sync clear, wins over
//        habilita), habilita (count enable), limite (terminal value), expira, contagem.
module temporizador_porta #(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         zera_as,
   input  logic         zera,
   input  logic         habilita,
   input  logic [N-1:0] limite,
   output logic         expira,
   output logic [N-1:0] contagem
);

   logic [N-1:0] cont_q;
   logic [N-1:0] cont_d;

   always_comb begin
      cont_d = cont_q;
      if (zera) begin
         cont_d = '0;
      end else if (habilita) begin
         cont_d = cont_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

   assign expira   = (cont_q == limite);
   assign contagem = cont_q;

endmodule

// File: rtl/controle_porta.sv
// controle_porta: elevator cab door sequencer (FECHADA -> ABRINDO -> ABERTA -> FECHANDO).
// Ports: clock, zera_as (async active-high reset); pedido_abrir/parado from the main FSM,
//        sensor_obstrucao/botao_abrir/botao_fechar from the cab; motor_abre/motor_fecha,
//        porta_fechada, db_estado (Moore), pronto (registered pulse), alarme.
// Optional: define CONTROLE_PORTA_ALARME_EN for the sticky reopen alarm; otherwise alarme=0.
module controle_porta
   import controle_porta_pkg::*;
#(
   parameter int T_ABRE     = T_ABRE_DEF,
   parameter int T_ESPERA   = T_ESPERA_DEF,
   parameter int T_FECHA    = T_FECHA_DEF,
   parameter int N          = N_DEF,
   parameter int MAX_REABRE = MAX_REABRE_DEF
) (
   input  logic       clock,
   input  logic       zera_as,
   input  logic       pedido_abrir,
   input  logic       parado,
   input  logic       sensor_obstrucao,
   input  logic       botao_abrir,
   input  logic       botao_fechar,
   output logic       motor_abre,
   output logic       motor_fecha,
   output logic       porta_fechada,
   output logic       pronto,
   output logic [1:0] db_estado,
   output logic       alarme
);

   // Reject configurations the timer cannot represent.
   if (T_ABRE < 1 || T_ESPERA < 1 || T_FECHA < 1 || MAX_REABRE < 1 ||
       (2**N) < T_ABRE || (2**N) < T_ESPERA || (2**N) < T_FECHA) begin : g_param_invalido
      $error("controle_porta: invalid timing parameters");
   end

   estado_t      estado_q;
   estado_t      estado_d;
   logic         pronto_q;
   logic         pronto_d;
   logic         zera_tmp;
   logic         habilita_tmp;
   logic [N-1:0] limite;
   logic         expira;
   logic [N-1:0] contagem;
   logic         pedido_valido;
   logic         manter_aberta;
   logic         reabrir;
   logic         fechar_ok;
   logic         alarme_ativo;

   assign pedido_valido = pedido_abrir & parado;
   assign manter_aberta = sensor_obstrucao | botao_abrir | pedido_abrir;
   assign reabrir       = sensor_obstrucao | botao_abrir;
   // With the alarm raised the door may only close by timeout.
   assign fechar_ok     = botao_fechar & ~alarme_ativo;

   // Limit follows the current phase so expira means "last cycle of this phase".
   assign limite       = N'(duracao_fase(estado_q, T_ABRE, T_ESPERA, T_FECHA) - 1);
   assign habilita_tmp = (estado_q != FECHADA);

   temporizador_porta #(
      .N (N)
   ) u_temporizador (
      .clock    (clock),
      .zera_as  (zera_as),
      .zera     (zera_tmp),
      .habilita (habilita_tmp),
      .limite   (limite),
      .expira   (expira),
      .contagem (contagem)
   );

   always_comb begin
      estado_d = estado_q;
      pronto_d = 1'b0;
      zera_tmp = 1'b0;
      case (estado_q)
         FECHADA: begin
            if (pedido_valido) begin
               estado_d = ABRINDO;
            end
         end
         ABRINDO: begin
            if (expira) begin
               estado_d = ABERTA;
            end
         end
         ABERTA: begin
            // Any open-type activity restarts the full wait and beats botao_fechar.
            if (manter_aberta) begin
               zera_tmp = 1'b1;
            end else if (fechar_ok || expira) begin
               estado_d = FECHANDO;
            end
         end
         FECHANDO: begin
            // Reopening wins even on the final closing cycle.
            if (reabrir) begin
               estado_d = ABRINDO;
            end else if (expira) begin
               estado_d = FECHADA;
               pronto_d = 1'b1;
            end
         end
         default: begin
            estado_d = FECHADA;
         end
      endcase
      if (estado_d != estado_q) begin
         zera_tmp = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         estado_q <= FECHADA;
         pronto_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pronto_q <= pronto_d;
      end
   end

`ifdef CONTROLE_PORTA_ALARME_EN
   localparam int RW = (MAX_REABRE < 2) ? 1 : $clog2(MAX_REABRE + 1);

   logic [RW-1:0] reabre_q;
   logic [RW-1:0] reabre_d;
   logic          alarme_q;
   logic          alarme_d;
   logic          reabriu;
   logic          fechou;

   assign reabriu = (estado_q == FECHANDO) && (estado_d == ABRINDO);
   assign fechou  = (estado_q == FECHANDO) && (estado_d == FECHADA);

   always_comb begin
      reabre_d = reabre_q;
      alarme_d = alarme_q;
      if (reabriu) begin
         if (reabre_q != RW'(MAX_REABRE)) begin
            reabre_d = reabre_q + 1'b1;
         end
         // Sticky: stays set until the door actually finishes closing.
         if (reabre_d == RW'(MAX_REABRE)) begin
            alarme_d = 1'b1;
         end
      end
      if (fechou) begin
         reabre_d = '0;
         alarme_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         reabre_q <= '0;
         alarme_q <= 1'b0;
      end else begin
         reabre_q <= reabre_d;
         alarme_q <= alarme_d;
      end
   end

   assign alarme_ativo = alarme_q;
`else
   assign alarme_ativo = 1'b0;
`endif

   assign motor_abre    = (estado_q == ABRINDO);
   assign motor_fecha   = (estado_q == FECHANDO);
   assign porta_fechada = (estado_q == FECHADA);
   assign db_estado     = estado_q;
   assign pronto        = pronto_q;
   assign alarme        = alarme_ativo;

endmodule

// File: tb/tb_controle_porta.sv
// tb_controle_porta: directed scenarios plus randomized traffic for controle_porta,
// compared every cycle against a phase/remaining-cycles model of the door.
// Works with or without CONTROLE_PORTA_ALARME_EN.
module tb_controle_porta;

   localparam int T_ABRE     = 4;
   localparam int T_ESPERA   = 8;
   localparam int T_FECHA    = 4;
   localparam int MAX_REABRE = 3;

   logic       clock;
   logic       zera_as;
   logic       pedido_abrir;
   logic       parado;
   logic       sensor_obstrucao;
   logic       botao_abrir;
   logic       botao_fechar;
   logic       motor_abre;
   logic       motor_fecha;
   logic       porta_fechada;
   logic       pronto;
   logic [1:0] db_estado;
   logic       alarme;

   int vetores = 0;
   int falhas  = 0;
   bit ativo   = 0;

   controle_porta #(
      .T_ABRE     (T_ABRE),
      .T_ESPERA   (T_ESPERA),
      .T_FECHA    (T_FECHA),
      .N          (4),
      .MAX_REABRE (MAX_REABRE)
   ) dut (
      .clock            (clock),
      .zera_as          (zera_as),
      .pedido_abrir     (pedido_abrir),
      .parado           (parado),
      .sensor_obstrucao (sensor_obstrucao),
      .botao_abrir      (botao_abrir),
      .botao_fechar     (botao_fechar),
      .motor_abre       (motor_abre),
      .motor_fecha      (motor_fecha),
      .porta_fechada    (porta_fechada),
      .pronto           (pronto),
      .db_estado        (db_estado),
      .alarme           (alarme)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      vetores++;
      if (atual !== esperado) begin
         falhas++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phase 0..3 = closed, opening, open, closing; m_resta counts cycles left in the phase.
   int m_fase   = 0;
   int m_resta  = 0;
   bit m_pronto = 0;
   bit m_alarme = 0;
   int m_reab   = 0;

   always @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         m_fase = 0; m_resta = 0; m_pronto = 0; m_alarme = 0; m_reab = 0;
      end else begin
         m_pronto = 0;
         case (m_fase)
            0: if (pedido_abrir && parado) begin
                  m_fase = 1; m_resta = T_ABRE;
               end
            1: begin
                  m_resta = m_resta - 1;
                  if (m_resta == 0) begin m_fase = 2; m_resta = T_ESPERA; end
               end
            2: if (sensor_obstrucao || botao_abrir || pedido_abrir) begin
                  m_resta = T_ESPERA;
               end else if (botao_fechar && !m_alarme) begin
                  m_fase = 3; m_resta = T_FECHA;
               end else begin
                  m_resta = m_resta - 1;
                  if (m_resta == 0) begin m_fase = 3; m_resta = T_FECHA; end
               end
            default: if (sensor_obstrucao || botao_abrir) begin
                  m_fase = 1; m_resta = T_ABRE;
`ifdef CONTROLE_PORTA_ALARME_EN
                  if (m_reab < MAX_REABRE) m_reab = m_reab + 1;
                  if (m_reab == MAX_REABRE) m_alarme = 1;
`endif
               end else begin
                  m_resta = m_resta - 1;
                  if (m_resta == 0) begin
                     m_fase = 0; m_pronto = 1; m_reab = 0; m_alarme = 0;
                  end
               end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (ativo) begin
         chk("db_estado",     db_estado,     m_fase);
         chk("motor_abre",    motor_abre,    m_fase == 1);
         chk("motor_fecha",   motor_fecha,   m_fase == 3);
         chk("porta_fechada", porta_fechada, m_fase == 0);
         chk("pronto",        pronto,        m_pronto);
         chk("alarme",        alarme,        m_alarme);
         chk("motores_exclusivos", motor_abre & motor_fecha, 0);
         assert (!(motor_abre && motor_fecha)) else $error("FAIL both motors driven");
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic entradas_zero();
      pedido_abrir = 0; parado = 0; sensor_obstrucao = 0; botao_abrir = 0; botao_fechar = 0;
   endtask

   task automatic espera_estado(input int e, input int limite);
      bit achou = 0;
      for (int i = 0; i < limite; i++) begin
         if (db_estado == e) begin achou = 1; break; end
         tick();
      end
      if (!achou) chk("timeout_espera_estado", db_estado, e);
   endtask

   task automatic pedir_abertura();
      pedido_abrir = 1; parado = 1;
      tick();
      pedido_abrir = 0;
   endtask

   initial begin
      int n_abre, n_fecha, n_pronto, idx_pronto, dur;
      entradas_zero();
      zera_as = 1;
      #2;
      chk("reset_estado",  db_estado, 0);
      chk("reset_fechada", porta_fechada, 1);
      chk("reset_motores", {motor_abre, motor_fecha}, 0);
      chk("reset_pronto",  pronto, 0);
      chk("reset_alarme",  alarme, 0);
      @(posedge clock); #1;
      zera_as = 0;
      ativo = 1;
      tick();

      // Nominal cycle: 4 opening, 8 open, 4 closing, pronto 17 cycles after the edge.
      pedir_abertura();
      n_abre = 0; n_fecha = 0; n_pronto = 0; idx_pronto = 0;
      for (int i = 1; i <= 22; i++) begin
         if (motor_abre) n_abre++;
         if (motor_fecha) n_fecha++;
         if (pronto) begin n_pronto++; idx_pronto = i; end
         tick();
      end
      chk("nominal_ciclos_abre",  n_abre, 4);
      chk("nominal_ciclos_fecha", n_fecha, 4);
      chk("nominal_pulsos_pronto", n_pronto, 1);
      chk("nominal_latencia_pronto", idx_pronto, 17);

      // Request while the cab is moving is ignored.
      pedido_abrir = 1; parado = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("sem_parado_estado", db_estado, 0);
      chk("sem_parado_motores", {motor_abre, motor_fecha}, 0);
      entradas_zero();
      tick();

      // Hold open: botao_abrir at ABERTA cycle 6 stretches ABERTA to 15 cycles.
      pedir_abertura();
      espera_estado(2, 10);
      for (int i = 0; i < 6; i++) tick();
      botao_abrir = 1;
      tick();
      botao_abrir = 0;
      dur = 7;
      for (int i = 0; i < 30 && db_estado == 2; i++) begin dur++; tick(); end
      chk("abertura_estendida", dur, 15);
      espera_estado(0, 40);
      tick();

      // botao_fechar together with an obstruction keeps the door open.
      pedir_abertura();
      espera_estado(2, 10);
      botao_fechar = 1; sensor_obstrucao = 1;
      tick();
      botao_fechar = 0; sensor_obstrucao = 0;
      chk("fechar_com_obstrucao", db_estado, 2);

      // Obstruction on the last closing cycle reopens for a full T_ABRE.
      espera_estado(3, 20);
      for (int i = 0; i < 3; i++) tick();
      sensor_obstrucao = 1;
      tick();
      sensor_obstrucao = 0;
      chk("obstrucao_final_estado", db_estado, 1);
      chk("obstrucao_final_pronto", pronto, 0);
      n_abre = 0;
      for (int i = 0; i < 10 && motor_abre; i++) begin n_abre++; tick(); end
      chk("obstrucao_final_ciclos_abre", n_abre, 4);
      espera_estado(0, 40);
      tick();

`ifdef CONTROLE_PORTA_ALARME_EN
      // Three consecutive reopenings raise the alarm; botao_fechar is then ignored.
      pedir_abertura();
      for (int r = 0; r < 3; r++) begin
         espera_estado(3, 30);
         sensor_obstrucao = 1;
         tick();
         sensor_obstrucao = 0;
      end
      chk("alarme_ativo", alarme, 1);
      espera_estado(2, 10);
      botao_fechar = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("alarme_ignora_fechar", db_estado, 2);
      end
      botao_fechar = 0;
      for (int i = 0; i < 40 && !pronto; i++) tick();
      chk("alarme_pronto", pronto, 1);
      chk("alarme_limpo_com_pronto", alarme, 0);
      tick();
`endif

      // Reset in the middle of ABRINDO drops the motor before the next edge.
      pedir_abertura();
      tick();
      chk("pre_reset_abrindo", db_estado, 1);
      #2;
      zera_as = 1;
      #1;
      chk("reset_meio_motor_abre", motor_abre, 0);
      chk("reset_meio_fechada", porta_fechada, 1);
      chk("reset_meio_estado", db_estado, 0);
      @(posedge clock); #1;
      zera_as = 0;
      tick();

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 3000; i++) begin
         pedido_abrir     = ($urandom_range(0, 7) == 0);
         parado           = ($urandom_range(0, 3) != 0);
         sensor_obstrucao = ($urandom_range(0, 15) == 0);
         botao_abrir      = ($urandom_range(0, 15) == 0);
         botao_fechar     = ($urandom_range(0, 5) == 0);
         zera_as          = ($urandom_range(0, 499) == 0);
         tick();
      end
      entradas_zero();
      zera_as = 0;
      tick();
      tick();
      ativo = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
      $finish;
   end

endmodule
